// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory port bundle for mem_access_unit.
// The slave modport is the unit; the master side is the requester and memory.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] dm_rd;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, dm_rd,
    input  req_ready, resp_valid, resp_rdata, resp_exc, dm_we, dm_addr, dm_wd, dm_pc
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, dm_rd,
    output req_ready, resp_valid, resp_rdata, resp_exc, dm_we, dm_addr, dm_wd, dm_pc
  );
endinterface

// File: rtl/mem_access_unit.sv
// CPU-side load/store initiator for a word-only data memory: alignment/range checks,
// read-modify-write for sub-word stores, sign/zero extension, one response per request.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  state_t      state, state_nx;
  op_t         in_op, op_q;
  logic [31:0] addr_q, wdata_q, pc_q, rbuf;
  logic        exc_q;
  logic        accept, req_exc;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] merged;

  assign in_op  = op_t'(bus.req_op);
  assign accept = bus.req_valid && (state == S_IDLE);

  always_comb begin
    req_exc = (bus.req_addr >= ADDR_LIMIT);
    case (in_op)
      OP_LW, OP_SW:         if (bus.req_addr[1:0] != 2'b00) req_exc = 1'b1;
      OP_LH, OP_LHU, OP_SH: if (bus.req_addr[0])            req_exc = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      exc_q   <= 1'b0;
      rbuf    <= '0;
    end else begin
      if (accept) begin
        op_q    <= in_op;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        pc_q    <= bus.req_pc;
        exc_q   <= req_exc;
      end
      if (state == S_READ) rbuf <= bus.dm_rd;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (req_exc)              state_nx = S_RESP;
          else if (in_op == OP_SW)  state_nx = S_WRITE;
          else                      state_nx = S_READ;
        end
      end
      S_READ:  state_nx = (op_q == OP_SH || op_q == OP_SB) ? S_WRITE : S_RESP;
      S_WRITE: state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Lane extraction and store merge both key off the latched byte offset.
  always_comb begin
    lane_b = rbuf[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? rbuf[31:16] : rbuf[15:0];
    merged = rbuf;
    case (op_q)
      OP_SW:   merged = wdata_q;
      OP_SH:   if (addr_q[1]) merged[31:16] = wdata_q[15:0];
               else           merged[15:0]  = wdata_q[15:0];
      OP_SB:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      default: ;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_exc   = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_addr    = '0;
    bus.dm_wd      = '0;
    bus.dm_pc      = '0;
    if (state != S_IDLE) begin
      bus.dm_addr = {addr_q[31:2], 2'b00};
      bus.dm_pc   = pc_q;
    end
    case (state)
      S_IDLE:  bus.req_ready = 1'b1;
      S_WRITE: begin
        bus.dm_we = ~reset;
        bus.dm_wd = merged;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_exc   = exc_q;
        if (!exc_q) begin
          case (op_q)
            OP_LW:   bus.resp_rdata = rbuf;
            OP_LH:   bus.resp_rdata = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  bus.resp_rdata = {16'h0000, lane_h};
            OP_LB:   bus.resp_rdata = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  bus.resp_rdata = {24'h000000, lane_b};
            default: bus.resp_rdata = '0;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset-abort and back-to-back
// sequences, then random requests against a byte-level reference model.
module tb_mem_access_unit;
  localparam int unsigned MEM_WORDS = 1024;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_mem = 1'b1;
  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  int          we_count = 0;
  logic [31:0] last_wd, last_we_addr, last_we_pc;
  int          n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  assign bus.dm_rd = (bus.dm_addr < MEM_BYTES) ? mem[bus.dm_addr[11:2]] : '0;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= init_word(i);
    end else if (bus.dm_we) begin
      mem[bus.dm_addr[11:2]] <= bus.dm_wd;
      we_count++;
      last_wd      = bus.dm_wd;
      last_we_addr = bus.dm_addr;
      last_we_pc   = bus.dm_pc;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: memory seen as bytes; a request touches `size` consecutive bytes.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic ex, output int lat, output int nwe);
    int unsigned size, w, k;
    logic [31:0] v;
    size = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
    ex   = ((a % size) != 0) || (a >= MEM_BYTES);
    rd   = '0;
    nwe  = 0;
    lat  = 1;
    if (ex) return;
    w = a / 4;
    if (op >= SW) begin
      for (int unsigned i = 0; i < size; i++) begin
        k = (a % 4) + i;
        ref_mem[w] = (ref_mem[w] & ~(32'hFF << (8 * k))) | (((wd >> (8 * i)) & 32'hFF) << (8 * k));
      end
      nwe = 1;
      lat = (size == 4) ? 2 : 3;
    end else begin
      v = '0;
      for (int unsigned i = 0; i < size; i++) begin
        k = (a % 4) + i;
        v = v | (((ref_mem[w] >> (8 * k)) & 32'hFF) << (8 * i));
      end
      if ((op == LH || op == LB) && v[8 * size - 1]) v = v | ~((32'h1 << (8 * size)) - 1);
      rd  = v;
      lat = 2;
    end
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] pc, output logic [31:0] rd, output logic ex,
                        output int lat, output int nwe);
    int w, base;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_before_request", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_pc    = pc;
    base = we_count;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    rd  = 'x;
    ex  = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = c;
        rd  = bus.resp_rdata;
        ex  = bus.resp_exc;
        break;
      end
    end
    @(negedge clk);
    check("resp_valid_one_cycle", 32'(bus.resp_valid), 32'd0);
    check("req_ready_after_resp", 32'(bus.req_ready), 32'd1);
    nwe = we_count - base;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        exc;
    int          lat;
    int          nwe;
    logic [31:0] wword;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic exc, input int lat,
                              input int nwe, input logic [31:0] wword);
    vec_t v;
    v.op = op; v.addr = a; v.wd = wd; v.rd = rd; v.exc = exc;
    v.lat = lat; v.nwe = nwe; v.wword = wword;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd, mrd, pc;
    logic        ex, mex;
    int          lat, nwe, mlat, mnwe, base, rcyc, acyc, bad_words;
    bit          seen;

    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_pc    = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = init_word(i);

    @(posedge clk);
    #1 load_mem = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_exc",   32'(bus.resp_exc),   32'd0);
    check("rst_resp_rdata", bus.resp_rdata,      32'd0);
    check("rst_dm_we",      32'(bus.dm_we),      32'd0);
    check("rst_dm_addr",    bus.dm_addr,         32'd0);
    check("rst_dm_wd",      bus.dm_wd,           32'd0);
    check("rst_dm_pc",      bus.dm_pc,           32'd0);

    vecs.push_back(mk(SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF));
    vecs.push_back(mk(LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mk(SW,  32'h10, 32'h11223344, 32'h0,        1'b0, 2, 1, 32'h11223344));
    vecs.push_back(mk(SB,  32'h12, 32'h000000AA, 32'h0,        1'b0, 3, 1, 32'h11AA3344));
    vecs.push_back(mk(LW,  32'h10, 32'h0,        32'h11AA3344, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mk(SW,  32'h20, 32'h80FF7F01, 32'h0,        1'b0, 2, 1, 32'h80FF7F01));
    vecs.push_back(mk(LB,  32'h22, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mk(LBU, 32'h23, 32'h0,        32'h00000080, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mk(LH,  32'h20, 32'h0,        32'h00007F01, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mk(LHU, 32'h22, 32'h0,        32'h000080FF, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mk(SH,  32'h22, 32'hCAFE1234, 32'h0,        1'b0, 3, 1, 32'h12347F01));
    vecs.push_back(mk(LW,  32'h13, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0));
    vecs.push_back(mk(SH,  32'h11, 32'h5555,     32'h0,        1'b1, 1, 0, 32'h0));
    vecs.push_back(mk(SW,  32'h1000, 32'h1,      32'h0,        1'b1, 1, 0, 32'h0));
    vecs.push_back(mk(LB,  32'hFFFFFFFF, 32'h0,  32'h0,        1'b1, 1, 0, 32'h0));
    vecs.push_back(mk(LBU, 32'hFFF, 32'h0,       init_word(1023) >> 24, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mk(LW,  32'h10, 32'h0,        32'h11AA3344, 1'b0, 2, 0, 32'h0));

    foreach (vecs[i]) begin
      pc = 32'h400 + 32'(i) * 4;
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wd, pc, rd, ex, lat, nwe);
      model(vecs[i].op, vecs[i].addr, vecs[i].wd, mrd, mex, mlat, mnwe);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      check($sformatf("vec%0d_exc", i), 32'(ex), 32'(vecs[i].exc));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_we_pulses", i), 32'(nwe), 32'(vecs[i].nwe));
      if (vecs[i].nwe != 0) begin
        check($sformatf("vec%0d_dm_wd", i), last_wd, vecs[i].wword);
        check($sformatf("vec%0d_dm_addr", i), last_we_addr, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("vec%0d_dm_pc", i), last_we_pc, pc);
      end
    end

    // Reset during the READ cycle of a byte store must abort it silently.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = SB;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h55;
    bus.req_pc    = 32'h900;
    base = we_count;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_dm_addr_in_read", bus.dm_addr, 32'h10);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    check("abort_no_write", 32'(we_count - base), 32'd0);
    do_req(LW, 32'h10, 32'h0, 32'h904, rd, ex, lat, nwe);
    check("abort_mem_unchanged", rd, 32'h11AA3344);

    // Requester holds req_valid high across two back-to-back requests.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = LW;
    bus.req_addr  = 32'h20;
    bus.req_pc    = 32'hA00;
    @(posedge clk);
    #1 begin
      bus.req_op   = LBU;
      bus.req_addr = 32'h23;
      bus.req_pc   = 32'hA04;
    end
    rcyc = 0;
    acyc = 0;
    rd   = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid && rcyc == 0) begin
        rcyc = c;
        rd   = bus.resp_rdata;
      end
      if (bus.req_ready) begin
        acyc = c;
        break;
      end
    end
    check("b2b_first_rdata", rd, 32'h12347F01);
    check("b2b_first_latency", 32'(rcyc), 32'd2);
    check("b2b_second_accept_cycle", 32'(acyc), 32'(rcyc + 1));
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rcyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        rcyc = c;
        rd   = bus.resp_rdata;
        break;
      end
    end
    check("b2b_second_latency", 32'(rcyc), 32'd2);
    check("b2b_second_rdata", rd, 32'h00000012);

    for (int n = 0; n < 300; n++) begin
      logic [2:0]  op;
      logic [31:0] a, wd;
      int unsigned r;
      op = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h1000 + $urandom_range(0, 15) - 32'd8;
      else             a = 32'($urandom_range(0, 63));
      wd = $urandom;
      pc = $urandom;
      do_req(op, a, wd, pc, rd, ex, lat, nwe);
      model(op, a, wd, mrd, mex, mlat, mnwe);
      check($sformatf("rnd%0d_rdata op%0d a%08h", n, op, a), rd, mrd);
      check($sformatf("rnd%0d_exc", n), 32'(ex), 32'(mex));
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(mlat));
      check($sformatf("rnd%0d_we_pulses", n), 32'(nwe), 32'(mnwe));
      if (mnwe != 0) begin
        check($sformatf("rnd%0d_dm_wd", n), last_wd, ref_mem[a[11:2]]);
        check($sformatf("rnd%0d_dm_pc", n), last_we_pc, pc);
      end
    end

    @(negedge clk);
    bad_words = 0;
    for (int i = 0; i < int'(MEM_WORDS); i++) if (mem[i] !== ref_mem[i]) bad_words++;
    check("final_memory_words_differing", 32'(bad_words), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
